// File: rtl/lmi_dram_arb.sv
// Local data RAM arbiter: core load/store pipe vs. DMA requester.
// One access per cycle, registered RAM strobes, tagged read return.
module lmi_dram_arb #(
    parameter int ADDR_HI    = 13,
    parameter int ADDR_LO    = 2,
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 8
) (
    input  logic                 CLK,
    input  logic                 RESET_D1_R_N,
    input  logic                 CFG_DMA_PRI,
    input  logic                 CORE_REQ,
    input  logic                 CORE_WR,
    input  logic [ADDR_HI:ADDR_LO] CORE_ADDR,
    input  logic [3:0]           CORE_BE,
    input  logic [31:0]          CORE_WDATA,
    output logic                 CORE_ACK,
    output logic                 CORE_HALT,
    output logic                 CORE_RVAL_R,
    output logic [31:0]          CORE_RDATA,
    input  logic                 EXT_REQ,
    input  logic                 EXT_WR,
    input  logic [ADDR_HI:ADDR_LO] EXT_ADDR,
    input  logic [3:0]           EXT_BE,
    input  logic [31:0]          EXT_WDATA,
    input  logic                 EXT_LAST,
    output logic                 EXT_GNT,
    output logic                 EXT_RVAL_R,
    output logic [31:0]          EXT_RDATA,
    output logic [ADDR_HI:ADDR_LO] RAM_INDEX_R,
    output logic [31:0]          RAM_WDATA_R,
    output logic [3:0]           RAM_BE_R,
    output logic                 RAM_CS_R,
    output logic                 RAM_WE_R,
    input  logic [31:0]          RAM_RDATA
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [3:0] BURST_LIM  = 4'(BURST_MAX);

    typedef enum logic {OWN_CORE, OWN_EXT} owner_t;

    owner_t      owner;
    logic [3:0]  starve_cnt;
    logic [3:0]  burst_cnt;
    logic        rd_tag_r;
    logic [31:0] core_hold_r;
    logic [31:0] ext_hold_r;
    logic        sw_ext;
    logic        yield;
    logic        acc;

    assign sw_ext = EXT_REQ & (~CORE_REQ | CFG_DMA_PRI |
                               (starve_cnt == STARVE_LIM));
    assign yield  = CORE_REQ & ~CFG_DMA_PRI & (burst_cnt == BURST_LIM);

    always_comb begin
        CORE_ACK = 1'b0;
        EXT_GNT  = 1'b0;
        if (owner == OWN_CORE) begin
            EXT_GNT  = sw_ext;
            CORE_ACK = CORE_REQ & ~sw_ext;
        end else if (yield) begin
            CORE_ACK = 1'b1;
        end else if (EXT_REQ) begin
            EXT_GNT = 1'b1;
        end else begin
            CORE_ACK = CORE_REQ;
        end
    end

    assign acc        = CORE_ACK | EXT_GNT;
    assign CORE_HALT  = CORE_REQ & ~CORE_ACK;
    assign CORE_RDATA = CORE_RVAL_R ? RAM_RDATA : core_hold_r;
    assign EXT_RDATA  = EXT_RVAL_R ? RAM_RDATA : ext_hold_r;

    always_ff @(posedge CLK) begin
        if (!RESET_D1_R_N) begin
            owner       <= OWN_CORE;
            starve_cnt  <= '0;
            burst_cnt   <= '0;
            rd_tag_r    <= 1'b0;
            RAM_CS_R    <= 1'b0;
            RAM_WE_R    <= 1'b0;
            RAM_BE_R    <= '0;
            RAM_INDEX_R <= '0;
            RAM_WDATA_R <= '0;
            CORE_RVAL_R <= 1'b0;
            EXT_RVAL_R  <= 1'b0;
            core_hold_r <= '0;
            ext_hold_r  <= '0;
        end else begin
            if (owner == OWN_CORE) begin
                if (sw_ext) begin
                    // the switch beat itself is the first beat of the burst
                    owner      <= OWN_EXT;
                    starve_cnt <= '0;
                    burst_cnt  <= 4'd1;
                end else if (!EXT_REQ) begin
                    starve_cnt <= '0;
                end else if (CORE_ACK && starve_cnt != STARVE_LIM) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                if (yield || !EXT_REQ || EXT_LAST) begin
                    owner     <= OWN_CORE;
                    burst_cnt <= '0;
                end else if (burst_cnt != BURST_LIM) begin
                    burst_cnt <= burst_cnt + 4'd1;
                end
            end

            RAM_CS_R <= acc;
            RAM_WE_R <= acc & (EXT_GNT ? EXT_WR : CORE_WR);
            if (acc) begin
                RAM_INDEX_R <= EXT_GNT ? EXT_ADDR : CORE_ADDR;
                RAM_BE_R    <= EXT_GNT ? EXT_BE : CORE_BE;
                RAM_WDATA_R <= EXT_GNT ? EXT_WDATA : CORE_WDATA;
                rd_tag_r    <= EXT_GNT;
            end

            CORE_RVAL_R <= RAM_CS_R & ~RAM_WE_R & ~rd_tag_r;
            EXT_RVAL_R  <= RAM_CS_R & ~RAM_WE_R & rd_tag_r;
            if (CORE_RVAL_R)
                core_hold_r <= RAM_RDATA;
            if (EXT_RVAL_R)
                ext_hold_r <= RAM_RDATA;
        end
    end

endmodule

// File: tb/tb_lmi_dram_arb.sv
// Directed bench for lmi_dram_arb with a behavioural RAM and a
// read-return scoreboard keyed by expected return cycle.
module tb_lmi_dram_arb;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, cfg_pri;
    logic        core_req, core_wr;
    logic [11:0] core_addr;
    logic [3:0]  core_be;
    logic [31:0] core_wdata;
    logic        ext_req, ext_wr, ext_last;
    logic [11:0] ext_addr;
    logic [3:0]  ext_be;
    logic [31:0] ext_wdata;
    logic        core_ack, core_halt, core_rval, ext_gnt, ext_rval;
    logic [31:0] core_rdata, ext_rdata;
    logic [11:0] ram_index;
    logic [31:0] ram_wdata, ram_rdata;
    logic [3:0]  ram_be;
    logic        ram_cs, ram_we;

    lmi_dram_arb dut (
        .CLK(clk), .RESET_D1_R_N(rst_n), .CFG_DMA_PRI(cfg_pri),
        .CORE_REQ(core_req), .CORE_WR(core_wr), .CORE_ADDR(core_addr),
        .CORE_BE(core_be), .CORE_WDATA(core_wdata),
        .CORE_ACK(core_ack), .CORE_HALT(core_halt),
        .CORE_RVAL_R(core_rval), .CORE_RDATA(core_rdata),
        .EXT_REQ(ext_req), .EXT_WR(ext_wr), .EXT_ADDR(ext_addr),
        .EXT_BE(ext_be), .EXT_WDATA(ext_wdata), .EXT_LAST(ext_last),
        .EXT_GNT(ext_gnt), .EXT_RVAL_R(ext_rval), .EXT_RDATA(ext_rdata),
        .RAM_INDEX_R(ram_index), .RAM_WDATA_R(ram_wdata),
        .RAM_BE_R(ram_be), .RAM_CS_R(ram_cs), .RAM_WE_R(ram_we),
        .RAM_RDATA(ram_rdata)
    );

    logic [31:0] mem [0:4095];
    logic [31:0] exp_mem [0:4095];

    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_index][8*b +: 8] = ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= mem[ram_index];
            end
        end
    end

    typedef struct {
        int          due;
        logic        ext;
        logic [31:0] data;
    } rd_t;

    typedef struct {
        logic        v;
        logic        we;
        logic [11:0] idx;
        logic [3:0]  be;
        logic [31:0] wd;
    } acc_t;

    rd_t         sb[$];
    acc_t        prev;
    int          tests = 0;
    int          fails = 0;
    int          cyc_n = 0;
    logic        have_core, have_ext;
    logic [31:0] last_core, last_ext;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic ea, input logic eg,
                       input logic rz = 1'b0);
        logic cdue, edue;
        acc_t a;
        rd_t  r;
        @(negedge clk);
        chk("core_ack", 32'(core_ack), 32'(ea));
        chk("ext_gnt", 32'(ext_gnt), 32'(eg));
        chk("core_halt", 32'(core_halt), 32'(core_req & ~ea));
        chk("ram_cs", 32'(ram_cs), 32'(prev.v));
        if (prev.v) begin
            chk("ram_we", 32'(ram_we), 32'(prev.we));
            chk("ram_index", 32'(ram_index), 32'(prev.idx));
            chk("ram_be", 32'(ram_be), 32'(prev.be));
            if (prev.we)
                chk("ram_wdata", ram_wdata, prev.wd);
        end
        if (rz) begin
            chk("rst_we", 32'(ram_we), 32'd0);
            chk("rst_index", 32'(ram_index), 32'd0);
            chk("rst_be", 32'(ram_be), 32'd0);
            chk("rst_wdata", ram_wdata, 32'd0);
        end
        cdue = sb.size() > 0 && sb[0].due == cyc_n && !sb[0].ext;
        edue = sb.size() > 0 && sb[0].due == cyc_n && sb[0].ext;
        chk("core_rval", 32'(core_rval), 32'(cdue));
        chk("ext_rval", 32'(ext_rval), 32'(edue));
        if (cdue) begin
            chk("core_rdata", core_rdata, sb[0].data);
            last_core = sb[0].data;
            have_core = 1'b1;
            void'(sb.pop_front());
        end else if (edue) begin
            chk("ext_rdata", ext_rdata, sb[0].data);
            last_ext = sb[0].data;
            have_ext = 1'b1;
            void'(sb.pop_front());
        end
        if (!cdue && have_core)
            chk("core_hold", core_rdata, last_core);
        if (!edue && have_ext)
            chk("ext_hold", ext_rdata, last_ext);
        a.v   = ea | eg;
        a.we  = eg ? ext_wr : core_wr;
        a.idx = eg ? ext_addr : core_addr;
        a.be  = eg ? ext_be : core_be;
        a.wd  = eg ? ext_wdata : core_wdata;
        if (a.v && !a.we) begin
            r.due  = cyc_n + 2;
            r.ext  = eg;
            r.data = exp_mem[a.idx];
            sb.push_back(r);
        end
        if (a.v && a.we)
            for (int b = 0; b < 4; b++)
                if (a.be[b]) exp_mem[a.idx][8*b +: 8] = a.wd[8*b +: 8];
        if (!a.v) a.we = 1'b0;
        prev = a;
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int eb, cb;
        logic ea, eg;
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 32'hA5A5_0000 | 32'(i);
            exp_mem[i] = 32'hA5A5_0000 | 32'(i);
        end
        rst_n = 1'b0; cfg_pri = 1'b0;
        core_req = 1'b0; core_wr = 1'b0; core_addr = '0;
        core_be = 4'hF; core_wdata = '0;
        ext_req = 1'b0; ext_wr = 1'b0; ext_addr = '0;
        ext_be = 4'hF; ext_wdata = '0; ext_last = 1'b0;
        prev = '{default: '0};
        have_core = 1'b0; have_ext = 1'b0;
        last_core = '0; last_ext = '0;
        @(posedge clk);
        #1;
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        rst_n = 1'b1;

        // core-only reads
        core_req = 1'b1; core_wr = 1'b0;
        core_addr = 12'h010; cyc(1, 0);
        core_addr = 12'h011; cyc(1, 0);
        core_req = 1'b0;
        repeat (3) cyc(0, 0);

        // DMA 4-beat write burst, then core read-back
        ext_req = 1'b1; ext_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ext_addr  = 12'h020 + 12'(i);
            ext_wdata = 32'(i + 1);
            ext_last  = (i == 3);
            cyc(0, 1);
        end
        ext_req = 1'b0; ext_last = 1'b0;
        cyc(0, 0);
        core_req = 1'b1; core_addr = 12'h022; cyc(1, 0);
        core_req = 1'b0;
        repeat (2) cyc(0, 0);
        chk("burst_wdata", exp_mem[12'h022], 32'd3);

        // contention: core wins STARVE_MAX times then DMA
        core_req = 1'b1; ext_req = 1'b1; ext_wr = 1'b0;
        ext_addr = 12'h030;
        for (int i = 0; i < 4; i++) begin
            core_addr = 12'h012 + 12'(i);
            cyc(1, 0);
        end
        cyc(0, 1);
        ext_req = 1'b0;
        core_addr = 12'h020; cyc(1, 0);
        core_req = 1'b0;
        repeat (2) cyc(0, 0);

        // long DMA burst with waiting core: yield then resume
        eb = 0; cb = 0;
        for (int c = 0; c < 18; c++) begin
            ext_req   = (c <= 16);
            core_req  = (c >= 1);
            ext_addr  = 12'h040 + 12'(eb);
            core_addr = 12'h050 + 12'(cb);
            ea = (c >= 8 && c <= 12) || c == 17;
            eg = ext_req && !ea;
            cyc(ea, eg);
            if (eg) eb++;
            if (ea) cb++;
        end
        ext_req = 1'b0; core_req = 1'b0;
        repeat (2) cyc(0, 0);
        chk("burst_beats", 32'(eb), 32'd12);

        // DMA fixed priority: core locked out
        cfg_pri = 1'b1; core_req = 1'b1; core_addr = 12'h061;
        ext_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ext_wr    = (i % 2 == 0);
            ext_addr  = 12'h060 + 12'(i / 2);
            ext_wdata = 32'hD000_0000 + 32'(i);
            cyc(0, 1);
        end
        cfg_pri = 1'b0; ext_req = 1'b0;
        cyc(1, 0);
        core_req = 1'b0;
        repeat (2) cyc(0, 0);

        // partial byte write then read, and DMA write / core read handoff
        core_req = 1'b1; core_wr = 1'b1; core_addr = 12'h070;
        core_be = 4'b0001; core_wdata = 32'hFFFF_FFFF;
        cyc(1, 0);
        core_wr = 1'b0; core_be = 4'hF;
        cyc(1, 0);
        core_req = 1'b0;
        ext_req = 1'b1; ext_wr = 1'b1; ext_addr = 12'h071;
        ext_wdata = 32'h1234_5678; ext_last = 1'b1;
        cyc(0, 1);
        ext_req = 1'b0; ext_last = 1'b0;
        core_req = 1'b1; core_addr = 12'h071;
        cyc(1, 0);
        core_req = 1'b0;
        repeat (2) cyc(0, 0);
        chk("be_merge", exp_mem[12'h070], 32'hA5A5_00FF);

        // reset with a read in flight
        core_req = 1'b1; core_addr = 12'h010;
        cyc(1, 0);
        core_req = 1'b0; rst_n = 1'b0;
        ext_req = 1'b1; ext_wr = 1'b0; ext_addr = 12'h030;
        cyc(0, 1);
        sb.delete();
        prev = '{default: '0};
        have_core = 1'b0; have_ext = 1'b0;
        rst_n = 1'b1; core_req = 1'b1; core_addr = 12'h011;
        cyc(1, 0, 1);
        repeat (3) cyc(1, 0);
        ext_last = 1'b1;
        cyc(0, 1);
        core_req = 1'b0; ext_req = 1'b0; ext_last = 1'b0;
        repeat (3) cyc(0, 0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lmi_dram_arb.md
Name: lmi_dram_arb

Overview:
- Owns the single-port local data RAM and shares it between two requesters: the core load/store pipeline and an external (DMA) requester.
- Picks one access per cycle, issues registered RAM strobes, and returns read data to the requester that owns the access.
- Stalls the core while the DMA owns the RAM.
- Provides starvation-bounded fairness plus a fixed-priority override for DMA.

Parameters:
- ADDR_HI, 13, MSB of the word index into the RAM.
- ADDR_LO, 2, LSB of the word index (byte address bits 1:0 are dropped).
- STARVE_MAX, 4, maximum consecutive core grants while the DMA is waiting (range 1..15).
- BURST_MAX, 8, maximum consecutive DMA grants while the core is waiting (range 1..15).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET_D1_R_N  in  1  reset, synchronous, active-low.
- CFG_DMA_PRI  in  1  1 = DMA has fixed priority and starvation limits are ignored.
- CORE_REQ  in  1  core access request, valid for the cycle.
- CORE_WR  in  1  1 = write, 0 = read.
- CORE_ADDR  in  [ADDR_HI:ADDR_LO]  core word index.
- CORE_BE  in  4  core byte enables.
- CORE_WDATA  in  32  core write data.
- CORE_ACK  out  1  combinational; core access accepted this cycle.
- CORE_HALT  out  1  combinational; equals CORE_REQ & ~CORE_ACK.
- CORE_RVAL_R  out  1  core read data valid.
- CORE_RDATA  out  32  core read data.
- EXT_REQ  in  1  DMA access request.
- EXT_WR  in  1  DMA write.
- EXT_ADDR  in  [ADDR_HI:ADDR_LO]  DMA word index.
- EXT_BE  in  4  DMA byte enables.
- EXT_WDATA  in  32  DMA write data.
- EXT_LAST  in  1  last beat of the DMA burst.
- EXT_GNT  out  1  combinational; DMA access accepted this cycle.
- EXT_RVAL_R  out  1  DMA read data valid.
- EXT_RDATA  out  32  DMA read data.
- RAM_INDEX_R  out  [ADDR_HI:ADDR_LO]  RAM word index.
- RAM_WDATA_R  out  32  RAM write data.
- RAM_BE_R  out  4  RAM byte enables.
- RAM_CS_R  out  1  RAM chip select.
- RAM_WE_R  out  1  RAM write enable.
- RAM_RDATA  in  32  RAM read data; valid the cycle after RAM_CS_R & ~RAM_WE_R.

Behaviour:

Reset:
- On RESET_D1_R_N=0 at a clock edge: owner=CORE, starve_cnt=0, burst_cnt=0.
- RAM_CS_R, RAM_WE_R, RAM_BE_R, RAM_INDEX_R, RAM_WDATA_R are all 0.
- CORE_RVAL_R, EXT_RVAL_R and the read-tag register are 0.
- An in-flight read is dropped; no RVAL is produced for it after reset.

Ownership state machine (states CORE, EXT):
- CORE state, switch condition = EXT_REQ & (~CORE_REQ | CFG_DMA_PRI | starve_cnt==STARVE_MAX).
  - If the switch condition is true: EXT_GNT=1, CORE_ACK=0, next state EXT, starve_cnt cleared. There is no bubble cycle on the switch.
  - Otherwise CORE_ACK=CORE_REQ.
  - starve_cnt increments when CORE_ACK & EXT_REQ, and clears when EXT_REQ=0.
- EXT state: EXT_GNT=EXT_REQ, except when yielding.
  - Yield condition = CORE_REQ & ~CFG_DMA_PRI & burst_cnt==BURST_MAX.
  - On yield: CORE_ACK=1, EXT_GNT=0, next state CORE, burst_cnt cleared.
  - On EXT_GNT & EXT_LAST: next state CORE, burst_cnt cleared.
  - If EXT_REQ=0: grant the core if CORE_REQ, next state CORE.
  - Otherwise burst_cnt increments on each EXT_GNT.
- At most one of CORE_ACK and EXT_GNT is 1 in any cycle.
- Counters saturate and never wrap.

Access timing:
- Accept in cycle N. RAM_* registers are loaded from the winning requester and valid in cycle N+1.
- RAM_CS_R=0 in cycle N+1 if nothing was accepted in cycle N.
- RAM_WE_R=1 for writes only.
- For a read, a 1-bit tag (core/ext) is pipelined alongside the access. The matching *_RVAL_R is 1 in cycle N+2 with *_RDATA=RAM_RDATA. The non-matching RVAL stays 0.
- Read latency is 2 cycles from accept. A new access may be accepted every cycle, including read/write alternation and owner switches.
- Write-then-read to the same index in consecutive accepted cycles returns the new data (the RAM orders them).
- *_RDATA holds its last value while the corresponding RVAL=0.

Test Plan:
1. Core-only reads: CORE_REQ with indices 0x10, 0x11 in cycles 0–1 (RAM preloaded 0xA5A5_0010 / 0xA5A5_0011) -> CORE_ACK in cycles 0–1; RAM_CS_R in cycles 1–2; CORE_RVAL_R in cycles 2–3 with data 0xA5A5_0010 then 0xA5A5_0011; EXT_RVAL_R=0 throughout.
2. DMA-only 4-beat write burst (EXT_LAST on beat 4, data 1..4 to indices 0x20..0x23) -> EXT_GNT for 4 cycles, RAM_WE_R=1 for 4 cycles, owner back to CORE afterwards; core read of 0x22 returns 3.
3. Contention with STARVE_MAX=4: CORE_REQ and EXT_REQ both held from cycle 0 -> CORE_ACK in cycles 0–3; EXT_GNT in cycle 4; CORE_HALT=1 from cycle 4.
4. 12-beat DMA burst without EXT_LAST, core waiting, BURST_MAX=8 -> 8 EXT_GNT; 1 CORE_ACK on the yield cycle; then 4 more CORE_ACK; DMA resumes for the remaining beats.
5. CFG_DMA_PRI=1 with both requesting for 20 cycles -> EXT_GNT all 20 cycles; CORE_ACK=0 and CORE_HALT=1 throughout.
6. Core read accepted in cycle 0, reset asserted in cycle 1 -> CORE_RVAL_R=0 in cycle 2; all outputs at reset values; owner=CORE after release.
